// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch stage. IFETCH_MISALIGN_EN adds a misaligned flag to each entry.
package ifetch_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_DATA_W = 32;
    localparam logic [IF_DATA_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
`ifdef IFETCH_MISALIGN_EN
        logic                 misaligned;
`endif
    } fetch_entry_t;

    function automatic logic [IF_ADDR_W-1:0] word_addr(input logic [IF_ADDR_W-1:0] pc);
        return {pc[IF_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO for fetched entries; clear wins over push and pop in the same cycle.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding memory read, results buffered for decode, flush drops wrong-path work.
// Build option IFETCH_MISALIGN_EN: misaligned PCs bypass memory and are tagged through id_misaligned.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDRESS    = IF_ADDR_W,
    parameter int DATA       = IF_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS-1:0]           pc_in,
    input  logic                         pc_valid,
    output logic                         pc_ready,
    input  logic                         flush,
    output logic                         imem_req,
    output logic [ADDRESS-1:0]           imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [DATA-1:0]              imem_rdata,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [DATA-1:0]              id_instr,
    output logic [ADDRESS-1:0]           id_pc,
`ifdef IFETCH_MISALIGN_EN
    output logic                         id_misaligned,
`endif
    output ifetch_state_e                dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]  dbg_fifo_count
);

    // Handshakes: a transfer happens in a cycle where both sides are high
    // (pc_valid/pc_ready, imem_req/imem_gnt, id_valid/id_ready); a requester holds
    // its payload stable until the transfer, and imem_rvalid is a one-cycle data beat.

    ifetch_state_e      state_q, state_d;
    logic [ADDRESS-1:0] req_pc_q, req_pc_d;
    logic               discard_q, discard_d;

    fetch_entry_t push_entry;
    fetch_entry_t head_entry;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;

    ifetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (dbg_fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_pc_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
        end
    end

    // A fetch starts only when its result is guaranteed a FIFO slot.
    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        pc_ready   = 1'b0;
        imem_req   = 1'b0;
        fifo_push  = 1'b0;
        push_entry = '0;
        unique case (state_q)
            IDLE: begin
                if (pc_valid && !flush && !fifo_full) begin
`ifdef IFETCH_MISALIGN_EN
                    if (pc_in[1:0] != 2'b00) begin
                        fifo_push             = 1'b1;
                        push_entry.pc         = pc_in;
                        push_entry.instr      = '0;
                        push_entry.misaligned = 1'b1;
                        pc_ready              = 1'b1;
                    end else begin
                        state_d  = REQ;
                        req_pc_d = pc_in;
                    end
`else
                    state_d  = REQ;
                    req_pc_d = pc_in;
`endif
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    state_d = WAIT;
                    if (flush) begin
                        discard_d = 1'b1;
                    end else begin
                        pc_ready = 1'b1;
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (imem_rvalid) begin
                    state_d          = IDLE;
                    discard_d        = 1'b0;
                    fifo_push        = !discard_q && !flush;
                    push_entry.pc    = req_pc_q;
                    push_entry.instr = imem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_pop  = id_valid && id_ready;
    assign imem_addr = word_addr(req_pc_q);
    assign id_valid  = !fifo_empty;
    assign id_instr  = head_entry.instr;
    assign id_pc     = head_entry.pc;
    assign dbg_state = state_q;
`ifdef IFETCH_MISALIGN_EN
    assign id_misaligned = head_entry.misaligned;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a transaction-level model of fetched instructions.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  ifetch_state_e dbg_state;
  logic [1:0]  dbg_fifo_count;
  logic        mis_act;
`ifdef IFETCH_MISALIGN_EN
  logic        id_misaligned;
  assign mis_act = id_misaligned;
`else
  assign mis_act = 1'b0;
`endif

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
`ifdef IFETCH_MISALIGN_EN
    .id_misaligned  (id_misaligned),
`endif
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  int checks = 0;
  int passes = 0;

  // Expected entries {misaligned, pc, instr}: accepted fetches not yet consumed by decode
  logic [64:0] exp_q[$];
  logic [31:0] deliv_pc[$];
  int          deliv_cyc[$];
  bit          saw_deadbeef = 1'b0;
  bit          flushed_prev = 1'b0;

  // Bench stimulus state
  logic [31:0] pc_q[$];
  bit          id_ready_r = 1'b1;
  bit          flush_next = 1'b0;
  bit          rst_drv = 1'b0;
  int          gnt_wait = 0;
  int          rvalid_delay = 1;
  bit          mem_pend = 1'b0;
  int          rv_wait = 0;
  logic [31:0] mem_addr_l = '0;
  int          req_age = 0;
  int          cycle = 0;
  bit          last_req;
  bit          accepted;
  logic [31:0] last_addr;
  bit          last_flush;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("rst_pc_ready", pc_ready, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_id_instr", id_instr, 0);
      chk("rst_id_pc", id_pc, 0);
      exp_q.delete();
      flushed_prev = 1'b0;
    end else begin
      if (flushed_prev) chk("id_valid_after_flush", id_valid, 0);
      if (id_valid) begin
        if (id_instr == 32'hDEAD_BEEF) saw_deadbeef = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL head_unexpected: id_valid=1 pc=%0h instr=%0h, expected no entry", id_pc, id_instr);
        end else begin
          chk("head_entry", {mis_act, id_pc, id_instr}, exp_q[0]);
        end
        if (id_ready && !flush) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          deliv_pc.push_back(id_pc);
          deliv_cyc.push_back(cycle);
        end
      end
      if (imem_req) chk("imem_addr", imem_addr, {pc_in[31:2], 2'b00});
      if (flush) begin
        chk("pc_ready_in_flush", pc_ready, 0);
        exp_q.delete();
      end else if (pc_ready) begin
`ifdef IFETCH_MISALIGN_EN
        if (pc_in[1:0] != 2'b00) begin
          chk("misalign_no_req", imem_req, 0);
          exp_q.push_back({1'b1, pc_in, 32'h0});
        end else begin
          chk("ready_at_gnt", imem_req && imem_gnt, 1);
          exp_q.push_back({1'b0, pc_in, mem_word({pc_in[31:2], 2'b00})});
        end
`else
        chk("ready_at_gnt", imem_req && imem_gnt, 1);
        exp_q.push_back({1'b0, pc_in, mem_word({pc_in[31:2], 2'b00})});
`endif
      end
      flushed_prev = flush;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    bit g;
    rst         = rst_drv;
    pc_valid    = (pc_q.size() > 0);
    pc_in       = pc_valid ? pc_q[0] : 32'h0;
    id_ready    = id_ready_r;
    flush       = flush_next;
    imem_gnt    = imem_req && (req_age >= gnt_wait);
    imem_rvalid = mem_pend && (rv_wait == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr_l) : 32'h0;
    #2;
    last_req   = imem_req;
    last_addr  = imem_addr;
    accepted   = pc_ready;
    last_flush = flush;
    g          = imem_req && imem_gnt;
    @(posedge clk);
    if (imem_rvalid) mem_pend = 1'b0;
    else if (mem_pend) rv_wait--;
    if (g) begin
      mem_pend   = 1'b1;
      rv_wait    = rvalid_delay - 1;
      mem_addr_l = last_addr;
    end
    req_age = (last_req && !imem_gnt) ? req_age + 1 : 0;
    if (accepted && pc_q.size() > 0) void'(pc_q.pop_front());
    if (last_flush) pc_q.delete();
    flush_next = 1'b0;
    cycle++;
    @(negedge clk);
  endtask

  task automatic wait_accept(input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = accepted;
    end
    chk("wait_accept_timeout", ok, 1);
  endtask

  task automatic wait_idle(input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = (pc_q.size() == 0) && (exp_q.size() == 0) && !mem_pend && (dbg_state == IDLE);
    end
    chk("wait_idle_timeout", ok, 1);
  endtask

  task automatic clear_log();
    deliv_pc.delete();
    deliv_cyc.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc_cnt;
    int req_n;
    int addr_bad;
    rst = 1'b0; pc_valid = 1'b0; pc_in = '0; flush = 1'b0; id_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    rst_drv = 1'b0;
    repeat (3) tick();
    chk("reset_state", dbg_state, IDLE);
    chk("reset_count", dbg_fifo_count, 0);
    rst_drv = 1'b1;

    // Zero-wait memory, PCs 0,4,8: one instruction every 3 cycles
    clear_log();
    pc_q = '{32'h0, 32'h4, 32'h8};
    wait_idle(60);
    chk("t1_count", deliv_pc.size(), 3);
    if (deliv_pc.size() == 3) begin
      chk("t1_pc0", deliv_pc[0], 32'h0);
      chk("t1_pc1", deliv_pc[1], 32'h4);
      chk("t1_pc2", deliv_pc[2], 32'h8);
      chk("t1_gap01", deliv_cyc[1] - deliv_cyc[0], 3);
      chk("t1_gap12", deliv_cyc[2] - deliv_cyc[1], 3);
    end
    chk("t1_word4", mem_word(32'h4), 32'hC0DE_0004);

    // Decode stalled for 10 cycles: FIFO fills to 2, then drains in order
    clear_log();
    id_ready_r = 1'b0;
    pc_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (accepted) acc_cnt++;
      if (i >= 6) begin
        chk("t2_no_req", imem_req, 0);
        chk("t2_full", dbg_fifo_count, 2);
        chk("t2_valid", id_valid, 1);
      end
    end
    chk("t2_accepts", acc_cnt, 2);
    id_ready_r = 1'b1;
    wait_idle(80);
    chk("t2_count", deliv_pc.size(), 4);
    if (deliv_pc.size() == 4) begin
      chk("t2_pc0", deliv_pc[0], 32'h100);
      chk("t2_pc1", deliv_pc[1], 32'h104);
      chk("t2_pc2", deliv_pc[2], 32'h108);
      chk("t2_pc3", deliv_pc[3], 32'h10C);
    end

    // Flush while in WAIT: 0xDEADBEEF from PC 0x10 must be dropped
    clear_log();
    saw_deadbeef = 1'b0;
    rvalid_delay = 2;
    pc_q = '{32'h10};
    wait_accept(20);
    chk("t3_in_wait", dbg_state, WAIT);
    flush_next = 1'b1;
    tick();
    pc_q.push_back(32'h40);
    wait_idle(60);
    chk("t3_no_deadbeef", saw_deadbeef, 0);
    chk("t3_count", deliv_pc.size(), 1);
    if (deliv_pc.size() > 0) chk("t3_first_pc", deliv_pc[0], 32'h40);
    rvalid_delay = 1;

    // Grant held low 5 cycles: request and address stable, pc_ready only at grant
    gnt_wait = 5;
    pc_q = '{32'h24};
    req_n = 0;
    addr_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_req) begin
        req_n++;
        if (last_addr != 32'h24) addr_bad++;
      end
      if (accepted) break;
    end
    chk("t4_req_cycles", req_n, 6);
    chk("t4_addr_stable", addr_bad, 0);
    chk("t4_accepted", accepted, 1);
    gnt_wait = 0;
    wait_idle(40);

    // Reset in WAIT, then a stray rvalid arrives in IDLE
    rvalid_delay = 3;
    pc_q = '{32'h30};
    wait_accept(20);
    chk("t5_in_wait", dbg_state, WAIT);
    rst_drv = 1'b0;
    tick();
    tick();
    rst_drv = 1'b1;
    tick();
    chk("t5_state", dbg_state, IDLE);
    chk("t5_count", dbg_fifo_count, 0);
    chk("t5_id_valid", id_valid, 0);
    chk("t5_imem_req", imem_req, 0);
    tick();
    chk("t5_id_valid_later", id_valid, 0);
    rvalid_delay = 1;
    clear_log();
    pc_q = '{32'h34};
    wait_idle(40);
    chk("t5_after_pc", (deliv_pc.size() == 1) ? deliv_pc[0] : 32'hFFFF_FFFF, 32'h34);

    // Flush in REQ with same-cycle grant: word discarded
    clear_log();
    pc_q = '{32'h50};
    tick();
    chk("t6a_in_req", dbg_state, REQ);
    flush_next = 1'b1;
    tick();
    chk("t6a_to_wait", dbg_state, WAIT);
    pc_q.push_back(32'h54);
    wait_idle(40);
    chk("t6a_pc", (deliv_pc.size() == 1) ? deliv_pc[0] : 32'hFFFF_FFFF, 32'h54);

    // Flush in REQ without grant: request dropped
    clear_log();
    gnt_wait = 3;
    pc_q = '{32'h60};
    tick();
    tick();
    flush_next = 1'b1;
    tick();
    chk("t6b_req_dropped", imem_req, 0);
    chk("t6b_idle", dbg_state, IDLE);
    gnt_wait = 0;
    pc_q.push_back(32'h64);
    wait_idle(40);
    chk("t6b_pc", (deliv_pc.size() == 1) ? deliv_pc[0] : 32'hFFFF_FFFF, 32'h64);

`ifdef IFETCH_MISALIGN_EN
    // Misaligned PC bypasses memory
    id_ready_r = 1'b0;
    pc_q = '{32'h6};
    tick();
    chk("t7_accepted", accepted, 1);
    chk("t7_no_req", last_req, 0);
    chk("t7_valid", id_valid, 1);
    chk("t7_misaligned", id_misaligned, 1);
    chk("t7_pc", id_pc, 32'h6);
    chk("t7_instr", id_instr, 32'h0);
    id_ready_r = 1'b1;
    wait_idle(20);
`endif

    repeat (3) tick();
    chk("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
